alu_div_sched: RTL and testbench
================================

Name: alu_div_sched

Overview:
- Round-robin scheduler that shares one sequential signed 8-bit divider among NREQ requesters (ALU issue ports, test/debug port).
- Captures a requester's operands and pulses the divider's start input.
- Holds the divider operands stable for the whole operation, waits for the divider's done pulse, then returns the quotient to the owning requester.
- Adds a divide-by-zero flag and a watchdog timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 32, maximum cycles to wait in WAIT for div_done before aborting.
- CW, 6, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held high until that requester's gnt bit pulses.
- req_a  in  NREQ*8  packed signed dividends; slice i is [8i+7:8i].
- req_b  in  NREQ*8  packed signed divisors; same slicing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of requester i captured.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: response for requester i is on the rsp_* lines.
- rsp_quotient  out  16  signed quotient; shared by all requesters.
- rsp_dz  out  1  divisor was zero.
- rsp_timeout  out  1  watchdog expired; quotient forced to 0.
- busy  out  1  high in every state except IDLE.
- div_start  out  1  one-cycle start pulse to the divider.
- div_a  out  8  dividend to the divider; registered.
- div_b  out  8  divisor to the divider; registered.
- div_clear  out  1  one-cycle pulse; the top level ORs it into the divider's reset.
- div_quotient  in  16  divider result.
- div_done  in  1  divider one-cycle completion pulse.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Timeout counter is 0.
- Reset mid-operation: everything is abandoned and no rsp_valid is issued. Requesters keep req high and are re-served.
- States:
  - IDLE:
    - If req != 0, pick winner w = first set bit searching last+1, last+2, … (mod NREQ).
    - Register div_a = req_a[w], div_b = req_b[w], owner = w, dz = (req_b[w] == 0).
    - Set last = w and go to ISSUE.
    - With no request, stay in IDLE.
  - ISSUE (1 cycle):
    - gnt[owner] = 1 and div_start = 1.
    - Clear the timeout counter and go to WAIT.
  - WAIT:
    - div_a and div_b are held constant. The divider re-reads its operands after start, so they must not change here.
    - The counter increments each cycle.
    - div_done = 1: latch div_quotient and go to RESP.
    - Otherwise, counter == TIMEOUT-1: set the timeout flag, quotient = 0, pulse div_clear, go to RESP.
    - If div_done and the timeout fall in the same cycle, div_done wins and there is no timeout.
  - RESP (1 cycle):
    - rsp_valid[owner] = 1.
    - rsp_quotient = the latched quotient; the scheduler does not re-check the divider's divide-by-zero result and passes it through.
    - rsp_dz = dz.
    - rsp_timeout = the timeout flag.
    - Then go to IDLE.
- rsp_quotient, rsp_dz and rsp_timeout hold their last values outside RESP. Benches sample them only while rsp_valid is high.
- Requester contract:
  - Drop req, or present a new operation, no earlier than the cycle after its gnt pulse.
  - A requester whose req stays high after its RESP is granted again only per round-robin order.
- Throughput: one operation in flight. Minimum spacing between grants is divider latency + 3 cycles (IDLE, ISSUE, RESP).
- A req bit that falls before its grant is simply not served. No latching of pending requests.
- A div_done seen in IDLE, ISSUE or RESP (a stray pulse) is ignored.
- div_start is never asserted while busy, except in ISSUE.

Decomposition:
- Shared package alu_pkg:
  - State encoding localparams: S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3.
  - DATA_W = 8 and RES_W = 16, shared with the other arithmetic units.
- One natural sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], last index.
  - Outputs: one-hot winner, winner index, any.
  - Reusable for the multiplier scheduler.

Test Plan:
- Single request: requester 0, a=100, b=7 -> gnt[0] pulses 1 cycle after req is seen; div_a=100, div_b=7 stable until RESP; rsp_valid[0] with rsp_quotient=0x000E, rsp_dz=0, rsp_timeout=0.
- Signs: requester 2, a=-100, b=7 -> 0xFFF2; a=-100, b=-7 -> 0x000E; a=-128, b=1 -> 0xFF80.
- Divide by zero: a=55, b=0 -> rsp_dz=1, rsp_quotient=0x0000, rsp_timeout=0.
- Contention: req=4'b1011 held, all raised in the same cycle, each dropped after its gnt -> grant order 0,1,3. Then req=4'b1001 with last=3 -> 0 first, then 3. No requester granted twice while another waits.
- Timeout: divider stub never asserts done, TIMEOUT=32 -> rsp_valid 33 cycles after ISSUE with rsp_timeout=1, quotient 0; div_clear pulses exactly once; next request is served normally.
- Reset in WAIT: assert reset for 1 cycle mid-operation -> all outputs 0 next cycle, no rsp_valid; the still-held req is re-granted with requester 0 priority; a stray div_done in IDLE produces no response.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic-unit schedulers.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after index 'last'.
module rr_pick
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Scan last+1 .. last+NREQ (mod NREQ); the first hit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IW'((int'(last) + k) % int'(NREQ));
      if (!any && req[cand]) begin
        any           = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_div_sched.sv
// Round-robin scheduler sharing one sequential signed divider among NREQ requesters.
module alu_div_sched
  import alu_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CW      = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [RES_W-1:0]         rsp_quotient,
  output logic                     rsp_dz,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic                     div_start,
  output logic [DATA_W-1:0]        div_a,
  output logic [DATA_W-1:0]        div_b,
  output logic                     div_clear,
  input  logic [RES_W-1:0]         div_quotient,
  input  logic                     div_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              dz_q, dz_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] div_a_q, div_a_d;
  logic [DATA_W-1:0] div_b_q, div_b_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_quotient_q, rsp_quotient_d;
  logic              rsp_dz_q, rsp_dz_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              busy_q, busy_d;
  logic              div_start_q, div_start_d;
  logic              div_clear_q, div_clear_d;

  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] a_arr [NREQ];
  logic [DATA_W-1:0] b_arr [NREQ];
  logic              wd_expired;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .last    (last_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Unpack the per-requester operand buses.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = req_a[i*DATA_W +: DATA_W];
      b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end
  end

  assign wd_expired = (cnt_q == CW'(TIMEOUT - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      last_q         <= IW'(NREQ - 1);
      owner_q        <= '0;
      dz_q           <= 1'b0;
      cnt_q          <= '0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      gnt_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_quotient_q <= '0;
      rsp_dz_q       <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
      div_start_q    <= 1'b0;
      div_clear_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      owner_q        <= owner_d;
      dz_q           <= dz_d;
      cnt_q          <= cnt_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      gnt_q          <= gnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_dz_q       <= rsp_dz_d;
      rsp_timeout_q  <= rsp_timeout_d;
      busy_q         <= busy_d;
      div_start_q    <= div_start_d;
      div_clear_q    <= div_clear_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_any) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (div_done || wd_expired) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; pulses are loaded one cycle ahead so
  // they appear registered in the state they belong to.
  always_comb begin
    last_d         = last_q;
    owner_d        = owner_q;
    dz_d           = dz_q;
    cnt_d          = cnt_q;
    div_a_d        = div_a_q;
    div_b_d        = div_b_q;
    gnt_d          = '0;
    rsp_valid_d    = '0;
    rsp_quotient_d = rsp_quotient_q;
    rsp_dz_d       = rsp_dz_q;
    rsp_timeout_d  = rsp_timeout_q;
    busy_d         = (state_d != S_IDLE);
    div_start_d    = 1'b0;
    div_clear_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          div_a_d     = a_arr[pick_idx];
          div_b_d     = b_arr[pick_idx];
          dz_d        = (b_arr[pick_idx] == '0);
          owner_d     = pick_idx;
          last_d      = pick_idx;
          gnt_d       = pick_oh;
          div_start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done pulse in the last watchdog cycle still counts as success.
        if (div_done) begin
          rsp_quotient_d = div_quotient;
          rsp_timeout_d  = 1'b0;
          rsp_dz_d       = dz_q;
          rsp_valid_d    = NREQ'(1) << owner_q;
        end else if (wd_expired) begin
          rsp_quotient_d = '0;
          rsp_timeout_d  = 1'b1;
          rsp_dz_d       = dz_q;
          rsp_valid_d    = NREQ'(1) << owner_q;
          div_clear_d    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign gnt          = gnt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_dz       = rsp_dz_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = busy_q;
  assign div_start    = div_start_q;
  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign div_clear    = div_clear_q;

endmodule

// File: tb/tb_alu_div_sched.sv
// Testbench for alu_div_sched: divider stub plus response scoreboard.
module tb_alu_div_sched;

  localparam int NREQ = 4;

  typedef struct {
    int          idx;
    logic [15:0] q;
    logic        dz;
    logic        to;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_quotient;
  logic        rsp_dz;
  logic        rsp_timeout;
  logic        busy;
  logic        div_start;
  logic [7:0]  div_a;
  logic [7:0]  div_b;
  logic        div_clear;
  logic [15:0] div_quotient;
  logic        div_done;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];
  int   gnt_log[$];

  int   stub_lat   = 4;
  logic stub_never = 1'b0;
  logic stray      = 1'b0;
  logic stub_busy;
  int   stub_cnt;

  alu_div_sched #(
    .NREQ    (4),
    .TIMEOUT (32),
    .CW      (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_quotient (rsp_quotient),
    .rsp_dz       (rsp_dz),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .div_start    (div_start),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_clear    (div_clear),
    .div_quotient (div_quotient),
    .div_done     (div_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signed 8-bit truncating division; a zero divisor yields 0.
  function automatic logic [15:0] div8(input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    if (b == 8'd0) return 16'h0000;
    x = {{24{a[7]}}, a};
    y = {{24{b[7]}}, b};
    return 16'(x / y);
  endfunction

  // Divider stub: reads its operands again when it finishes.
  always @(posedge clk) begin
    if (reset || div_clear) begin
      stub_busy    <= 1'b0;
      div_done     <= 1'b0;
      div_quotient <= 16'h0000;
    end else begin
      div_done <= stray;
      if (stray) div_quotient <= 16'h5A5A;
      if (div_start) begin
        stub_busy <= 1'b1;
        stub_cnt  <= stub_lat;
      end else if (stub_busy) begin
        if (stub_cnt == 1) begin
          stub_busy <= 1'b0;
          if (!stub_never) begin
            div_done     <= 1'b1;
            div_quotient <= div8(div_a, div_b);
          end
        end
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid != 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp rsp_valid=%b q=%h", rsp_valid, rsp_quotient);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== 4'(1 << e.idx) || rsp_quotient !== e.q ||
            rsp_dz !== e.dz || rsp_timeout !== e.to) begin
          failures++;
          $display("FAIL rsp got valid=%b q=%h dz=%b to=%b want valid=%b q=%h dz=%b to=%b",
                   rsp_valid, rsp_quotient, rsp_dz, rsp_timeout,
                   4'(1 << e.idx), e.q, e.dz, e.to);
        end
      end
    end
    if (!reset && gnt != 4'b0000) begin
      checks++;
      if (!$onehot(gnt)) begin
        failures++;
        $display("FAIL gnt_onehot got=%b want one-hot", gnt);
      end
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic push(input int idx, input logic [15:0] q, input logic dz, input logic to);
    exp_t e;
    e.idx = idx;
    e.q   = q;
    e.dz  = dz;
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic set_ops(input int idx, input int a, input int b);
    req_a[idx*8 +: 8] = 8'(a);
    req_b[idx*8 +: 8] = 8'(b);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    gnt_log.delete();
  endtask

  // Serve n grants, dropping each req bit on its grant, then drain responses.
  task automatic serve(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gnt != 4'b0000) begin
        req = req & ~gnt;
        got++;
      end
    end
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL serve_grants got=%0d want=%0d", got, n);
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL serve_drain pending=%0d want=0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_single(input int idx, input int a, input int b,
                             input logic [15:0] eq, input logic edz, output int lat);
    int   cyc;
    logic stable;
    logic [7:0] a8;
    logic [7:0] b8;
    a8 = 8'(a);
    b8 = 8'(b);
    push(idx, eq, edz, 1'b0);
    @(negedge clk);
    set_ops(idx, a, b);
    req[idx] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == 4'b0000 && cyc < 20);
    checks++;
    if (gnt !== 4'(1 << idx) || cyc != 1) begin
      failures++;
      $display("FAIL single_gnt got=%b after %0d want=%b after 1", gnt, cyc, 4'(1 << idx));
    end
    checks++;
    if (div_a !== a8 || div_b !== b8 || div_start !== 1'b1) begin
      failures++;
      $display("FAIL single_issue got a=%h b=%h start=%b want a=%h b=%h start=1",
               div_a, div_b, div_start, a8, b8);
    end
    req[idx] = 1'b0;
    stable = 1'b1;
    cyc = 0;
    while (rsp_valid == 4'b0000 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (div_a !== a8 || div_b !== b8) stable = 1'b0;
    end
    lat = cyc;
    checks++;
    if (rsp_valid == 4'b0000 || !stable) begin
      failures++;
      $display("FAIL single_hold got rsp=%b stable=%b want rsp!=0 stable=1", rsp_valid, stable);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    req_a = 32'h0;
    req_b = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, busy, div_start, div_clear} !== 11'b0) begin
      failures++;
      $display("FAIL reset_ctrl got gnt=%b rsp=%b busy=%b start=%b clr=%b want 0",
               gnt, rsp_valid, busy, div_start, div_clear);
    end
    checks++;
    if ({rsp_quotient, rsp_dz, rsp_timeout, div_a, div_b} !== 34'b0) begin
      failures++;
      $display("FAIL reset_data got q=%h dz=%b to=%b a=%h b=%h want 0",
               rsp_quotient, rsp_dz, rsp_timeout, div_a, div_b);
    end
    req   = 4'b0000;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signs();
    int lat;
    test_single(0, 100, 7, 16'h000E, 1'b0, lat);
    test_single(2, -100, 7, 16'hFFF2, 1'b0, lat);
    test_single(2, -100, -7, 16'h000E, 1'b0, lat);
    test_single(2, -128, 1, 16'hFF80, 1'b0, lat);
  endtask

  task automatic test_div_zero();
    int lat;
    test_single(1, 55, 0, 16'h0000, 1'b1, lat);
  endtask

  task automatic test_contention();
    reset_dut();
    push(0, 16'h000A, 1'b0, 1'b0);
    push(1, 16'hFFFC, 1'b0, 1'b0);
    push(3, 16'hFF81, 1'b0, 1'b0);
    @(negedge clk);
    set_ops(0, 50, 5);
    set_ops(1, -9, 2);
    set_ops(3, 127, -1);
    req = 4'b1011;
    serve(3);
    checks++;
    if (gnt_log.size() != 3 || gnt_log[0] != 0 || gnt_log[1] != 1 || gnt_log[2] != 3) begin
      failures++;
      $display("FAIL contention_order got=%p want 0,1,3", gnt_log);
    end
    gnt_log.delete();
    push(0, 16'h0001, 1'b0, 1'b0);
    push(3, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    set_ops(0, 7, 7);
    set_ops(3, -1, 3);
    req = 4'b1001;
    serve(2);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 3) begin
      failures++;
      $display("FAIL contention_wrap got=%p want 0,3", gnt_log);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int nclr;
    int lat;
    stub_never = 1'b1;
    push(1, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    set_ops(1, 20, 3);
    req[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == 4'b0000 && cyc < 20);
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL timeout_gnt got=%b want=0010", gnt);
    end
    cyc  = 0;
    nclr = 0;
    while (rsp_valid == 4'b0000 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (div_clear) nclr++;
    end
    checks++;
    if (cyc != 33) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=33", cyc);
    end
    repeat (3) begin
      @(negedge clk);
      if (div_clear) nclr++;
    end
    checks++;
    if (nclr != 1) begin
      failures++;
      $display("FAIL timeout_clear_pulses got=%0d want=1", nclr);
    end
    stub_never = 1'b0;
    test_single(1, 20, 3, 16'h0006, 1'b0, lat);
  endtask

  task automatic test_done_at_limit();
    int lat;
    stub_lat = 31;
    test_single(0, 90, 9, 16'h000A, 1'b0, lat);
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL done_at_limit_latency got=%0d want=33", lat);
    end
    stub_lat = 4;
  endtask

  task automatic test_reset_in_wait();
    int   cyc;
    int   lat;
    logic quiet;
    reset_dut();
    test_single(0, 9, 3, 16'h0003, 1'b0, lat);
    @(negedge clk);
    set_ops(1, 40, 4);
    set_ops(2, 30, 5);
    req = 4'b0110;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == 4'b0000 && cyc < 20);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL rstwait_first_gnt got=%b want=0010", gnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({gnt, rsp_valid, busy, div_start, div_clear, rsp_quotient, rsp_dz, rsp_timeout,
         div_a, div_b} !== 45'b0) begin
      failures++;
      $display("FAIL rstwait_outputs got gnt=%b rsp=%b busy=%b a=%h b=%h q=%h want 0",
               gnt, rsp_valid, busy, div_a, div_b, rsp_quotient);
    end
    gnt_log.delete();
    push(1, 16'h000A, 1'b0, 1'b0);
    push(2, 16'h0006, 1'b0, 1'b0);
    serve(2);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 1 || gnt_log[1] != 2) begin
      failures++;
      $display("FAIL rstwait_regrant got=%p want 1,2", gnt_log);
    end
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL stray_done got rsp=%b busy=%b want idle", rsp_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_div_zero();
    test_contention();
    test_timeout();
    test_done_at_limit();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
